// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave in front of a word-organised scratch memory.
// Supports programmable wait states, byte strobes and an error response.
//
// Ports:
//   pclk, preset      clock, synchronous active-high reset
//   psel, penable     APB phase control
//   pwrite, paddr     direction and byte address
//   pwdata, pstrb     write data and byte-lane enables
//   pready            registered transfer-complete
//   prdata, pslverr   read data and error; zero unless pready=1
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = 4;
    localparam int AXW   = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [AXW-1:0]        DEPTH_X  = AXW'(DEPTH);
    localparam logic [CW-1:0]         WS       = CW'(WAIT_STATES);
    localparam bit                    ZERO_WS  = (WAIT_STATES == 0);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         cnt_q;
    logic                  wr_q;
    logic                  err_q;
    logic [IDXW-1:0]       idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      strb_q;

    // Live address decode, used when the setup phase is sampled.
    logic [ADDR_WIDTH-1:0] word_a;
    logic [IDXW-1:0]       idx_live;
    logic                  err_live;

    assign word_a   = paddr >> OFFW;
    assign idx_live = word_a[IDXW-1:0];
    assign err_live = (|(paddr & OFF_MASK))
                   || ({1'b0, word_a} >= DEPTH_X);

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!psel || (penable && pready)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    logic                  setup;
    logic                  abort;
    logic                  done;
    logic                  tick;
    logic                  load;
    logic                  rsp_wr;
    logic                  rsp_err;
    logic [IDXW-1:0]       rsp_idx;
    logic [CW-1:0]         cnt_d;
    logic                  pready_d;
    logic                  pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_d;
    logic                  mem_we;

    always_comb begin
        setup = (state_q == S_IDLE) && psel && !penable;
        abort = (state_q == S_ACCESS) && !psel;
        done  = (state_q == S_ACCESS) && psel && penable && pready;
        tick  = (state_q == S_ACCESS) && psel && !pready;

        // With zero wait states the response is formed at the setup
        // edge from the live bus; otherwise from the captured request.
        load    = (setup && ZERO_WS) || (tick && (cnt_q == CW'(1)));
        rsp_wr  = setup ? pwrite   : wr_q;
        rsp_err = setup ? err_live : err_q;
        rsp_idx = setup ? idx_live : idx_q;

        cnt_d     = cnt_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        mem_we    = done && wr_q && !err_q;

        unique case (1'b1)
            setup: begin
                cnt_d    = WS;
                pready_d = ZERO_WS;
            end
            tick: begin
                cnt_d = cnt_q - CW'(1);
            end
            done, abort: begin
                cnt_d     = '0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: ;
        endcase

        if (load) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = (!rsp_wr && !rsp_err) ? mem[rsp_idx] : '0;
        end
    end

    // Response and captured-request registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
            if (setup) begin
                wr_q    <= pwrite;
                err_q   <= err_live;
                idx_q   <= idx_live;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
        end
    end

    // Memory array: cleared on reset, byte-lane writes on completion.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed bench
// for apb_mem_slave (default + 8-bit WS0).
module tb_apb_mem_slave;
  logic pclk;
  logic preset;

  logic        psel0;
  logic        penable0;
  logic        pwrite0;
  logic [11:0] paddr0;
  logic [31:0] pwdata0;
  logic [3:0]  pstrb0;
  logic        pready0;
  logic [31:0] prdata0;
  logic        pslverr0;

  logic        psel1;
  logic        penable1;
  logic        pwrite1;
  logic [7:0]  paddr1;
  logic [7:0]  pwdata1;
  logic [0:0]  pstrb1;
  logic        pready1;
  logic [7:0]  prdata1;
  logic        pslverr1;

  int n_tests = 0;
  int n_fail  = 0;

  apb_mem_slave u_dut0 (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel0),
    .penable (penable0),
    .pwrite  (pwrite0),
    .paddr   (paddr0),
    .pwdata  (pwdata0),
    .pstrb   (pstrb0),
    .pready  (pready0),
    .prdata  (prdata0),
    .pslverr (pslverr0)
  );

  apb_mem_slave #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (8),
    .DEPTH       (256),
    .WAIT_STATES (0)
  ) u_dut1 (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel1),
    .penable (penable1),
    .pwrite  (pwrite1),
    .paddr   (paddr1),
    .pwdata  (pwdata1),
    .pstrb   (pstrb1),
    .pready  (pready1),
    .prdata  (prdata1),
    .pslverr (pslverr1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input bit ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic xfer0(
    input  logic        wr,
    input  logic [11:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output int          waits,
    output logic [31:0] rd,
    output logic        err);
    @(negedge pclk);
    psel0 = 1'b1; penable0 = 1'b0;
    pwrite0 = wr; paddr0 = a;
    pwdata0 = d; pstrb0 = s;
    @(negedge pclk);
    penable0 = 1'b1; pwrite0 = !wr;
    paddr0 = ~a; pwdata0 = ~d;
    pstrb0 = ~s;
    waits = 0;
    while (!pready0 && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    rd  = prdata0;
    err = pslverr0;
  endtask

  task automatic xfer1(
    input  logic       wr,
    input  logic [7:0] a,
    input  logic [7:0] d,
    input  logic       s,
    output int         waits,
    output logic [7:0] rd,
    output logic       err);
    @(negedge pclk);
    psel1 = 1'b1; penable1 = 1'b0;
    pwrite1 = wr; paddr1 = a;
    pwdata1 = d; pstrb1 = s;
    @(negedge pclk);
    penable1 = 1'b1; pwrite1 = !wr;
    paddr1 = ~a; pwdata1 = ~d;
    pstrb1 = ~s;
    waits = 0;
    while (!pready1 && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    rd  = prdata1;
    err = pslverr1;
  endtask

  task automatic idle0();
    @(negedge pclk);
    psel0 = 1'b0; penable0 = 1'b0;
  endtask

  initial begin
    int          w;
    logic [31:0] rd;
    logic [7:0]  rd8;
    logic        e;

    preset = 1'b1;
    psel0 = 0; penable0 = 0; pwrite0 = 0;
    paddr0 = '0; pwdata0 = '0;
    pstrb0 = '0;
    psel1 = 0; penable1 = 0; pwrite1 = 0;
    paddr1 = '0; pwdata1 = '0;
    pstrb1 = '0;
    repeat (3) @(negedge pclk);
    chk("rst_pready", pready0 === 1'b0);
    chk("rst_prdata", prdata0 === 32'h0);
    chk("rst_pslverr", pslverr0 === 1'b0);
    chk("rst_pready1", pready1 === 1'b0);
    preset = 1'b0;

    xfer0(1'b0, 12'h010, 32'h0, 4'h0,
          w, rd, e);
    chk("rd010_lat", w == 2);
    chk("rd010_data", rd === 32'h0);
    chk("rd010_err", e === 1'b0);

    xfer0(1'b1, 12'h020, 32'hDEADBEEF,
          4'hF, w, rd, e);
    chk("wr020_lat", w == 2);
    chk("wr020_err", e === 1'b0);
    chk("wr020_prdata", rd === 32'h0);
    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_lat", w == 2);
    chk("rd020_data",
        rd === 32'hDEADBEEF);
    idle0();
    chk("done_pready", pready0 === 1'b0);
    chk("done_prdata",
        prdata0 === 32'h0);

    xfer0(1'b1, 12'h020, 32'h11223344,
          4'h5, w, rd, e);
    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_part",
        rd === 32'hDE22BE44);
    xfer0(1'b1, 12'h020, 32'hFFFFFFFF,
          4'h0, w, rd, e);
    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_nostrb",
        rd === 32'hDE22BE44);

    xfer0(1'b0, 12'h022, 32'h0, 4'h0,
          w, rd, e);
    chk("rd022_lat", w == 2);
    chk("rd022_err", e === 1'b1);
    chk("rd022_data", rd === 32'h0);
    xfer0(1'b1, 12'h400, 32'hFFFFFFFF,
          4'hF, w, rd, e);
    chk("wr400_err", e === 1'b1);
    xfer0(1'b1, 12'h021, 32'hFFFFFFFF,
          4'hF, w, rd, e);
    chk("wr021_err", e === 1'b1);
    xfer0(1'b0, 12'hFFC, 32'h0, 4'h0,
          w, rd, e);
    chk("rdFFC_err", e === 1'b1);
    xfer0(1'b0, 12'h000, 32'h0, 4'h0,
          w, rd, e);
    chk("rd000_data", rd === 32'h0);
    chk("rd000_err", e === 1'b0);
    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_keep",
        rd === 32'hDE22BE44);

    idle0();
    @(negedge pclk);
    psel0 = 1'b1; penable0 = 1'b1;
    repeat (3) @(negedge pclk);
    chk("idle_penable",
        pready0 === 1'b0);
    psel0 = 1'b0; penable0 = 1'b0;

    @(negedge pclk);
    psel0 = 1'b1; penable0 = 1'b0;
    pwrite0 = 1'b1;
    paddr0 = 12'h030;
    pwdata0 = 32'hCAFEF00D;
    pstrb0 = 4'hF;
    @(negedge pclk);
    penable0 = 1'b1;
    @(negedge pclk);
    chk("abort_pre", pready0 === 1'b0);
    psel0 = 1'b0; penable0 = 1'b0;
    @(negedge pclk);
    chk("abort_pready",
        pready0 === 1'b0);
    xfer0(1'b0, 12'h030, 32'h0, 4'h0,
          w, rd, e);
    chk("rd030_lat", w == 2);
    chk("rd030_data", rd === 32'h0);

    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_prerst",
        rd === 32'hDE22BE44);
    preset = 1'b1;
    @(negedge pclk);
    chk("midrst_pready",
        pready0 === 1'b0);
    chk("midrst_prdata",
        prdata0 === 32'h0);
    chk("midrst_pslverr",
        pslverr0 === 1'b0);
    preset = 1'b0;
    psel0 = 1'b0; penable0 = 1'b0;
    xfer0(1'b0, 12'h020, 32'h0, 4'h0,
          w, rd, e);
    chk("rd020_cleared", rd === 32'h0);
    idle0();

    xfer1(1'b1, 8'hFF, 8'hA5, 1'b1,
          w, rd8, e);
    chk("ws0_wr_lat", w == 0);
    chk("ws0_wr_err", e === 1'b0);
    xfer1(1'b0, 8'hFF, 8'h00, 1'b0,
          w, rd8, e);
    chk("ws0_rd_lat", w == 0);
    chk("ws0_rdFF", rd8 === 8'hA5);
    xfer1(1'b0, 8'hFE, 8'h00, 1'b0,
          w, rd8, e);
    chk("ws0_rdFE", rd8 === 8'h00);
    xfer1(1'b1, 8'h00, 8'h5A, 1'b0,
          w, rd8, e);
    xfer1(1'b0, 8'h00, 8'h00, 1'b0,
          w, rd8, e);
    chk("ws0_nostrb", rd8 === 8'h00);
    chk("ws0_err", e === 1'b0);
    @(negedge pclk);
    psel1 = 1'b0; penable1 = 1'b0;
    chk("ws0_done", pready1 === 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB slave with on-chip register memory. Replaces the fixed 8-bit, 256-entry, zero-wait slave. Adds:
- configurable data/address width and depth
- programmable wait states
- byte strobes (pstrb)
- error response (pslverr)
- synchronous reset

Sits on the APB peripheral bus behind the bridge as a scratch/config memory target.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8
ADDR_WIDTH, 12, byte address width of paddr
DEPTH, 256, number of DATA_WIDTH words; DEPTH*DATA_WIDTH/8 <= 2^ADDR_WIDTH
WAIT_STATES, 2, extra access-phase cycles before pready; 0..15

Ports:
pclk  input  1  APB clock; all logic on rising edge
preset  input  1  synchronous, active-high reset
psel  input  1  slave select
penable  input  1  access-phase indicator
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  byte address
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_WIDTH/8  write byte lanes; bit i enables pwdata[8i+7:8i]
pready  output  1  transfer complete (registered)
prdata  output  DATA_WIDTH  read data; valid only while pready=1 on a read, else 0
pslverr  output  1  error response; valid only while pready=1, else 0

Behaviour:
- Reset (preset=1 at posedge): state=IDLE, pready=0, prdata=0, pslverr=0, wait counter=0. All memory words cleared to 0. Reset overrides any transfer in progress; an in-flight write is not committed.
- BYTES = DATA_WIDTH/8. Word index = paddr >> log2(BYTES).
- Error condition ERR = (paddr mod BYTES != 0) OR (word index >= DEPTH).
- FSM states:
  - IDLE: on an edge sampling psel=1, penable=0 (setup phase), go to ACCESS. Capture paddr, pwrite, pwdata, pstrb and ERR into internal registers. Load counter=WAIT_STATES. Set pready <= (WAIT_STATES==0).
  - ACCESS, pready=0: counter decrements each edge. When counter==1, set pready<=1. Total pready latency after the setup edge is WAIT_STATES cycles. prdata and pslverr are loaded in the same edge that sets pready.
  - ACCESS, pready=1, psel=1, penable=1: the edge completes the transfer; go to IDLE and clear pready, prdata and pslverr to 0.
    - Write with ERR=0: for each lane with pstrb[i]=1, the byte is written at this edge.
    - Write with ERR=1, or pstrb all zero: memory is not modified.
  - ACCESS, psel=0 (protocol abort): go to IDLE, clear outputs, no memory write.
- Read data: on reads with ERR=0, prdata = mem[index] as of the pready-setting edge. With ERR=1, prdata=0. pslverr=ERR on both reads and writes.
- pstrb is ignored on reads.
- Back-to-back transfers: the next setup phase directly follows the completion cycle and is accepted normally from IDLE; no dead cycle is required.
- Read-after-write to the same address in consecutive transfers returns the newly written data.
- penable=1 while in IDLE (no setup seen) is ignored.
- Address/control changes during ACCESS are ignored; values captured at setup are used.

Test Plan:
1. Reset, then read addr 0x010 (defaults) -> pready rises 2 cycles after setup edge; prdata=0x00000000, pslverr=0.
2. Write 0xDEADBEEF to 0x020 with pstrb=0xF, then read 0x020 -> pready after 2 wait cycles on each transfer; prdata=0xDEADBEEF, pslverr=0.
3. Partial write of 0x11223344 to 0x020 with pstrb=0x5, then read 0x020 -> prdata=0xDE22BE44.
4. Read 0x022 (misaligned) and write 0x400 (index 256 >= DEPTH) -> pslverr=1 with pready on both, prdata=0. A following read of 0x000 returns 0 (memory unchanged).
5. Start a write of 0xCAFEF00D to 0x030, then drop psel after 1 access cycle -> no pready; a subsequent read of 0x030 returns 0. Also assert preset mid-transfer -> all outputs 0 the next cycle.
6. Rebuild with WAIT_STATES=0, DATA_WIDTH=8, ADDR_WIDTH=8, DEPTH=256 -> pready=1 in the first access cycle. Back-to-back write 0xA5 to 0xFF then read 0xFF -> prdata=0xA5, no idle cycle between transfers.
